// File: rtl/branch_predictor.sv
// Dynamic branch predictor with BTB: combinational fetch lookup, execute-stage
// update with 2-bit saturating counters, misprediction flag and perf counters.
module branch_predictor #(
  parameter int         ENTRIES     = 64,
  parameter int         ADDR_WIDTH  = 32,
  parameter int         COUNT_WIDTH = 32,
  parameter logic [1:0] ALLOC_INIT  = 2'b10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_WIDTH-1:0]  PCF,
  output logic                   PredTakenF,
  output logic [ADDR_WIDTH-1:0]  NextPCF,
  input  logic                   UpdateE,
  input  logic [ADDR_WIDTH-1:0]  PCE,
  input  logic                   TakenE,
  input  logic [ADDR_WIDTH-1:0]  TargetE,
  input  logic                   PredTakenE,
  input  logic [ADDR_WIDTH-1:0]  PredTargetE,
  output logic                   MispredictE,
  output logic [COUNT_WIDTH-1:0] BranchCount,
  output logic [COUNT_WIDTH-1:0] MispredCount
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_WIDTH - IDX - 2;

  logic [ENTRIES-1:0]    valid_all;
  logic [TAG_W-1:0]      tag_all    [ENTRIES];
  logic [ADDR_WIDTH-1:0] target_all [ENTRIES];
  logic [1:0]            ctr_all    [ENTRIES];

  logic [IDX-1:0]   idx_f, idx_e;
  logic [TAG_W-1:0] tag_f, tag_e;
  logic             hit_f, hit_e;
  logic             unused_low_bits;

  assign idx_f = PCF[IDX+1:2];
  assign tag_f = PCF[ADDR_WIDTH-1:IDX+2];
  assign idx_e = PCE[IDX+1:2];
  assign tag_e = PCE[ADDR_WIDTH-1:IDX+2];
  assign unused_low_bits = ^{PCF[1:0], PCE[1:0]};

  // Fetch reads pre-update contents; no bypass from the execute write.
  assign hit_f      = valid_all[idx_f] && (tag_all[idx_f] == tag_f);
  assign PredTakenF = hit_f && ctr_all[idx_f][1];
  assign NextPCF    = PredTakenF ? target_all[idx_f] : PCF + ADDR_WIDTH'(4);

  assign hit_e       = valid_all[idx_e] && (tag_all[idx_e] == tag_e);
  assign MispredictE = UpdateE && ((TakenE != PredTakenE) ||
                       (TakenE && PredTakenE && (TargetE != PredTargetE)));

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      logic                  valid_reg;
      logic [TAG_W-1:0]      tag_reg;
      logic [ADDR_WIDTH-1:0] target_reg;
      logic [1:0]            ctr_reg;
      logic                  sel;

      assign sel = UpdateE && (idx_e == IDX'(gi));

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          valid_reg  <= 1'b0;
          tag_reg    <= '0;
          target_reg <= '0;
          ctr_reg    <= 2'b01;
        end else if (sel) begin
          if (hit_e) begin
            if (TakenE) begin
              if (ctr_reg != 2'b11) ctr_reg <= ctr_reg + 2'b01;
              target_reg <= TargetE;
            end else if (ctr_reg != 2'b00) begin
              ctr_reg <= ctr_reg - 2'b01;
            end
          end else if (TakenE) begin
            // Miss on a taken branch replaces whatever held this index.
            valid_reg  <= 1'b1;
            tag_reg    <= tag_e;
            target_reg <= TargetE;
            ctr_reg    <= ALLOC_INIT;
          end
        end
      end

      assign valid_all[gi]  = valid_reg;
      assign tag_all[gi]    = tag_reg;
      assign target_all[gi] = target_reg;
      assign ctr_all[gi]    = ctr_reg;
    end
  endgenerate

  logic [COUNT_WIDTH-1:0] branch_count_reg, mispred_count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branch_count_reg  <= '0;
      mispred_count_reg <= '0;
    end else begin
      if (UpdateE && (branch_count_reg != '1))
        branch_count_reg <= branch_count_reg + 1'b1;
      if (MispredictE && (mispred_count_reg != '1))
        mispred_count_reg <= mispred_count_reg + 1'b1;
    end
  end

  assign BranchCount  = branch_count_reg;
  assign MispredCount = mispred_count_reg;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed test-plan steps plus
// randomized traffic compared against a per-index BTB reference model.
module tb_branch_predictor;

  localparam int ENTRIES = 64;
  localparam int AW      = 32;
  localparam int CW      = 4;
  localparam int CMAX    = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] PCF = '0;
  logic          PredTakenF;
  logic [AW-1:0] NextPCF;
  logic          UpdateE = 1'b0;
  logic [AW-1:0] PCE = '0;
  logic          TakenE = 1'b0;
  logic [AW-1:0] TargetE = '0;
  logic          PredTakenE = 1'b0;
  logic [AW-1:0] PredTargetE = '0;
  logic          MispredictE;
  logic [CW-1:0] BranchCount, MispredCount;

  branch_predictor #(.ENTRIES(ENTRIES), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW),
                     .ALLOC_INIT(2'b10)) dut (
    .clk(clk), .rst(rst), .PCF(PCF), .PredTakenF(PredTakenF), .NextPCF(NextPCF),
    .UpdateE(UpdateE), .PCE(PCE), .TakenE(TakenE), .TargetE(TargetE),
    .PredTakenE(PredTakenE), .PredTargetE(PredTargetE), .MispredictE(MispredictE),
    .BranchCount(BranchCount), .MispredCount(MispredCount));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: each slot remembers the word address (PC/4) of the
  // branch it holds, its target and a confidence level 0..3.
  bit          m_valid [ENTRIES];
  int unsigned m_word  [ENTRIES];
  logic [AW-1:0] m_tgt [ENTRIES];
  int          m_conf  [ENTRIES];
  int          m_bc, m_mc;

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_word[i] = 0; m_tgt[i] = '0; m_conf[i] = 1;
    end
    m_bc = 0; m_mc = 0;
  endfunction

  function automatic bit model_hit(logic [AW-1:0] pc);
    int slot = int'((pc / 4) % ENTRIES);
    return m_valid[slot] && (m_word[slot] == int'(pc / 4));
  endfunction

  function automatic bit model_taken(logic [AW-1:0] pc);
    return model_hit(pc) && (m_conf[int'((pc / 4) % ENTRIES)] >= 2);
  endfunction

  function automatic logic [AW-1:0] model_next(logic [AW-1:0] pc);
    if (model_taken(pc)) return m_tgt[int'((pc / 4) % ENTRIES)];
    return pc + 32'd4;
  endfunction

  function automatic bit model_misp(bit upd, bit tk, logic [AW-1:0] tgt,
                                    bit ptk, logic [AW-1:0] ptgt);
    if (!upd) return 0;
    if (tk != ptk) return 1;
    return tk && (tgt != ptgt);
  endfunction

  function automatic void model_update(bit upd, logic [AW-1:0] pc, bit tk,
                                       logic [AW-1:0] tgt, bit misp);
    int slot = int'((pc / 4) % ENTRIES);
    if (!upd) return;
    if (model_hit(pc)) begin
      if (tk) begin
        m_conf[slot] = (m_conf[slot] < 3) ? m_conf[slot] + 1 : 3;
        m_tgt[slot]  = tgt;
      end else begin
        m_conf[slot] = (m_conf[slot] > 0) ? m_conf[slot] - 1 : 0;
      end
    end else if (tk) begin
      m_valid[slot] = 1; m_word[slot] = int'(pc / 4); m_tgt[slot] = tgt; m_conf[slot] = 2;
    end
    m_bc = (m_bc < CMAX) ? m_bc + 1 : CMAX;
    if (misp) m_mc = (m_mc < CMAX) ? m_mc + 1 : CMAX;
  endfunction

  task automatic check(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at posedge+1, check fetch/mispredict before the edge,
  // then check the perf counters after it.
  task automatic step(input bit upd, input logic [AW-1:0] pce, input bit tk,
                      input logic [AW-1:0] tgt, input bit ptk,
                      input logic [AW-1:0] ptgt, input logic [AW-1:0] pcf);
    bit misp;
    UpdateE = upd; PCE = pce; TakenE = tk; TargetE = tgt;
    PredTakenE = ptk; PredTargetE = ptgt; PCF = pcf;
    #2;
    misp = model_misp(upd, tk, tgt, ptk, ptgt);
    check("pred_taken", {31'b0, PredTakenF}, {31'b0, model_taken(pcf)});
    check("next_pc", NextPCF, model_next(pcf));
    check("mispredict", {31'b0, MispredictE}, {31'b0, misp});
    @(posedge clk); #1;
    model_update(upd, pce, tk, tgt, misp);
    check("branch_count", {28'b0, BranchCount}, m_bc);
    check("mispred_count", {28'b0, MispredCount}, m_mc);
    $display("step upd=%0d pce=%h tk=%0d tgt=%h pcf=%h -> ptf=%0d npc=%h misp=%0d bc=%0d mc=%0d",
             upd, pce, tk, tgt, pcf, PredTakenF, NextPCF, MispredictE, BranchCount, MispredCount);
  endtask

  task automatic look(input logic [AW-1:0] pcf, input bit exp_tk, input logic [AW-1:0] exp_npc);
    UpdateE = 0; PCF = pcf; #2;
    check("look_taken", {31'b0, PredTakenF}, {31'b0, exp_tk});
    check("look_next", NextPCF, exp_npc);
    @(posedge clk); #1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Post-reset
    look(32'h100, 0, 32'h104);
    check("reset_bc", {28'b0, BranchCount}, 32'd0);
    check("reset_mc", {28'b0, MispredCount}, 32'd0);

    // Allocate 0x100 -> 0x80
    step(1, 32'h100, 1, 32'h80, 0, 32'h104, 32'h100);
    look(32'h100, 1, 32'h80);
    check("alloc_bc", {28'b0, BranchCount}, 32'd1);
    check("alloc_mc", {28'b0, MispredCount}, 32'd1);

    // Saturate then hysteresis
    repeat (3) step(1, 32'h100, 1, 32'h80, 1, 32'h80, 32'h100);
    step(1, 32'h100, 0, 32'h0, 1, 32'h80, 32'h100);
    look(32'h100, 1, 32'h80);
    step(1, 32'h100, 0, 32'h0, 1, 32'h80, 32'h100);
    look(32'h100, 0, 32'h104);

    // Alias eviction: 0x200 shares index 0 with 0x100
    step(1, 32'h200, 1, 32'h80, 0, 32'h204, 32'h0);
    look(32'h100, 0, 32'h104);
    look(32'h200, 1, 32'h80);

    // Target mismatch with same-cycle lookup sees old target
    step(1, 32'h200, 1, 32'h90, 1, 32'h80, 32'h200);
    look(32'h200, 1, 32'h90);

    // Randomized traffic over a small PC pool to force hits and aliasing
    for (int n = 0; n < 300; n++) begin
      logic [AW-1:0] pce, pcf, tgt, ptgt;
      bit upd, tk, ptk;
      pce  = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      pcf  = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      upd  = ($urandom_range(0, 3) != 0);
      tk   = $urandom_range(0, 1);
      tgt  = {$urandom_range(0, 7), 4'h0};
      if ($urandom_range(0, 1)) begin
        ptk = model_taken(pce); ptgt = model_next(pce);
      end else begin
        ptk = $urandom_range(0, 1); ptgt = {$urandom_range(0, 7), 4'h0};
      end
      step(upd, pce, tk, tgt, ptk, ptgt, pcf);
    end

    // Counter saturation: 20 more updates pin both near/at all-ones
    repeat (20) step(1, 32'h300, 1, 32'h40, 0, 32'h0, 32'h300);
    check("sat_bc", {28'b0, BranchCount}, 32'd15);
    check("sat_mc", {28'b0, MispredCount}, 32'd15);
    look(32'h300, 1, 32'h40);

    // Asynchronous reset mid-cycle, with a coincident update that is discarded
    UpdateE = 1; PCE = 32'h304; TakenE = 1; TargetE = 32'h50;
    PredTakenE = 0; PredTargetE = 32'h0; PCF = 32'h300;
    #2; rst = 1'b0; #1;
    check("arst_bc", {28'b0, BranchCount}, 32'd0);
    check("arst_mc", {28'b0, MispredCount}, 32'd0);
    check("arst_taken", {31'b0, PredTakenF}, 32'd0);
    check("arst_next", NextPCF, 32'h304);
    check("arst_misp_comb", {31'b0, MispredictE}, 32'd1);
    model_reset();
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b1; UpdateE = 0;
    @(posedge clk); #1;
    look(32'h304, 0, 32'h308);
    look(32'h300, 0, 32'h304);
    check("post_rst_bc", {28'b0, BranchCount}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
